mod_regn_piso_db: RTL

MOD_REGN_PISO_DB -- requirements
Module: mod_regN_piso_db

---
 rtl/mod_regn_piso_db.sv | 106 ++++++++++
 1 files changed

// File: rtl/mod_regn_piso_db.sv
// Double-buffered (ping-pong) parallel-in serial-out register: N lanes of W bits per word.
// Defining MOD_REGN_PISO_LAST_EN adds the o_last output flagging the final lane of a word.
module mod_regn_piso_db #(
    parameter int N = 16,
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [N-1:0][W-1:0] i,
    input  logic                wr_en,
    output logic                wr_rdy,
    input  logic                req_fifo,
    output logic [W-1:0]        o,
    output logic                o_valid,
    output logic                reg_empty,
    output logic                reg_full
`ifdef MOD_REGN_PISO_LAST_EN
    ,
    output logic                o_last
`endif
);

    localparam int            CW        = $clog2(N);
    localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

    logic [N-1:0][W-1:0] bank0_q;
    logic [N-1:0][W-1:0] bank1_q;
    logic [1:0]          occ_q;
    logic [1:0]          occ_d;
    logic                wr_ptr_q;
    logic                wr_ptr_d;
    logic                rd_ptr_q;
    logic                rd_ptr_d;
    logic [CW-1:0]       n_read_q;
    logic [CW-1:0]       n_read_d;
    logic                load;
    logic                xfer;
    logic                at_last;

    // Every output decodes registered state only; req_fifo never reaches wr_rdy.
    assign wr_rdy    = ~(occ_q[0] & occ_q[1]);
    assign o_valid   = occ_q[rd_ptr_q];
    assign o         = rd_ptr_q ? bank1_q[n_read_q] : bank0_q[n_read_q];
    assign reg_empty = ~occ_q[0] & ~occ_q[1];
    assign reg_full  = occ_q[0] & occ_q[1];

    assign load    = wr_en & wr_rdy;
    assign xfer    = req_fifo & o_valid;
    assign at_last = (n_read_q == LAST_LANE);

`ifdef MOD_REGN_PISO_LAST_EN
    assign o_last = o_valid & at_last;
`endif

    always_comb begin
        // NOTE: each variable gets a default first so no path leaves it unassigned (no latch).
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        n_read_d = n_read_q;

        if (xfer) begin
            if (at_last) begin
                n_read_d        = '0;
                occ_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = ~rd_ptr_q;
            end else begin
                n_read_d = n_read_q + CW'(1);
            end
        end

        // A load only happens with a free bank, which is never the bank being read out,
        // so it cannot collide with the occupied-flag clear above.
        if (load) begin
            occ_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = ~wr_ptr_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occ_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            n_read_q <= '0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            n_read_q <= n_read_d;
        end
    end

    // NOTE: the data banks are reset as well, so o reads 0 straight out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bank0_q <= '0;
            bank1_q <= '0;
        end else begin
            if (load && !wr_ptr_q) bank0_q <= i;
            if (load && wr_ptr_q)  bank1_q <= i;
        end
    end

endmodule
